// File: rtl/multi_pulse_gen_pkg.sv
// ---------------------------------------------------------------------------
// multi_pulse_gen_pkg
// Shared definitions for the multi-channel level-to-pulse generator:
//   - edge_mode_e : per-channel edge selection encoding
//   - SYNC_STAGES_DEF : default synchroniser depth
// Optional feature macro (used by the importing modules):
//   MULTI_PULSE_GEN_OVERRUN_EN
// ---------------------------------------------------------------------------
package multi_pulse_gen_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_mode_e;

  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/multi_pulse_gen_if.sv
// ---------------------------------------------------------------------------
// multi_pulse_gen_if
// Bundles the level inputs, configuration and pulse/overrun outputs of
// multi_pulse_gen.
//   i_signal   [CHANNELS]    level inputs (may be asynchronous to CLK)
//   i_edge_sel [2*CHANNELS]  per-channel mode, bits [2c+1:2c]
//   i_width    [WIDTH_W]     pulse length in cycles (0 behaves as 1)
//   i_clr                    synchronous clear of the overrun flags
//   o_pulse    [CHANNELS]    registered output pulses
//   o_overrun  [CHANNELS]    sticky merged-event flags
// There is no valid/ready handshake here: inputs are levels sampled every
// CLK edge and outputs are registered levels valid every cycle.
// master = stimulus side, slave = the generator.
// Optional feature macro: MULTI_PULSE_GEN_OVERRUN_EN (o_overrun stays 0
// when undefined; the signals remain so the port list is stable).
// ---------------------------------------------------------------------------
interface multi_pulse_gen_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH_W  = 4
);
  logic [CHANNELS-1:0]   i_signal;
  logic [2*CHANNELS-1:0] i_edge_sel;
  logic [WIDTH_W-1:0]    i_width;
  logic                  i_clr;
  logic [CHANNELS-1:0]   o_pulse;
  logic [CHANNELS-1:0]   o_overrun;

  modport master (
    output i_signal, i_edge_sel, i_width, i_clr,
    input  o_pulse, o_overrun
  );

  modport slave (
    input  i_signal, i_edge_sel, i_width, i_clr,
    output o_pulse, o_overrun
  );
endinterface

// File: rtl/multi_pulse_gen_pulse_chan.sv
// ---------------------------------------------------------------------------
// multi_pulse_gen_pulse_chan
// One channel: synchroniser chain, edge history, edge detector, pulse
// length counter and (optionally) a sticky overrun flag.
// Ports:
//   CLK, RST   clock, asynchronous active-low reset
//   sig_i      raw level input
//   mode_i     edge mode (edge_mode_e encoding)
//   width_i    pulse length, sampled only when a pulse is (re)triggered
//   clr_i      overrun clear (only used with the optional feature)
//   pulse_o    registered pulse output
//   overrun_o  sticky merged-event flag
// Optional feature macro: MULTI_PULSE_GEN_OVERRUN_EN
// ---------------------------------------------------------------------------
module multi_pulse_gen_pulse_chan
  import multi_pulse_gen_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int WIDTH_W     = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               sig_i,
  input  logic [1:0]         mode_i,
  input  logic [WIDTH_W-1:0] width_i,
  input  logic               clr_i,
  output logic               pulse_o,
  output logic               overrun_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q;
  logic [WIDTH_W-1:0]     cnt_q, cnt_d;
  logic                   pulse_q, pulse_d;
  edge_mode_e             mode;
  logic                   s, rise, fall, det;

  assign mode = edge_mode_e'(mode_i);

  // Written as a loop so a single-stage synchroniser needs no special case.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = sig_i;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~hist_q;
  assign fall = ~s & hist_q;

  always_comb begin
    det = 1'b0;
    case (mode)
      EDGE_RISE: det = rise;
      EDGE_FALL: det = fall;
      EDGE_BOTH: det = rise | fall;
      default:   det = 1'b0;
    endcase
  end

  // cnt holds the cycles still to run after the current one, so a trigger
  // loads W_eff-1 and the pulse drops one cycle after cnt reaches 0.
  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (mode == EDGE_OFF) begin
      cnt_d   = '0;
      pulse_d = 1'b0;
    end else if (det) begin
      cnt_d   = (width_i == '0) ? '0 : width_i - 1'b1;
      pulse_d = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d   = cnt_q - 1'b1;
      pulse_d = 1'b1;
    end
  end

  // History follows the synchroniser in every mode so that re-enabling a
  // channel compares against a current sample, not a stale one.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      hist_q  <= s;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

`ifdef MULTI_PULSE_GEN_OVERRUN_EN
  logic overrun_q;

  // A detect while the pulse is already high means an event was merged.
  // det is never set in EDGE_OFF, so disabled channels cannot flag.
  // Set has priority over a coincident clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= (det & pulse_q) | (overrun_q & ~clr_i);
    end
  end

  assign overrun_o = overrun_q;
`else
  logic clr_unused;
  assign clr_unused = clr_i;
  assign overrun_o  = 1'b0;
`endif

endmodule

// File: rtl/multi_pulse_gen.sv
// ---------------------------------------------------------------------------
// multi_pulse_gen
// Multi-channel level-to-pulse generator for CDC boundaries. Each channel
// synchronises its level input, detects the selected edge type and emits a
// registered pulse of programmable length, restarting on retrigger.
// Ports:
//   CLK   system clock
//   RST   asynchronous, active-low reset
//   bus   multi_pulse_gen_if.slave (i_signal, i_edge_sel, i_width, i_clr,
//         o_pulse, o_overrun)
// Parameters: CHANNELS (1..32), SYNC_STAGES (1..4), WIDTH_W.
// Optional feature macro: MULTI_PULSE_GEN_OVERRUN_EN enables the sticky
// per-channel overrun flags; otherwise o_overrun is constant 0.
// ---------------------------------------------------------------------------
module multi_pulse_gen
  import multi_pulse_gen_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int WIDTH_W     = 4
) (
  input logic              CLK,
  input logic              RST,
  multi_pulse_gen_if.slave bus
);

  logic [CHANNELS-1:0] pulse_w;
  logic [CHANNELS-1:0] overrun_w;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    multi_pulse_gen_pulse_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .WIDTH_W     (WIDTH_W)
    ) u_chan (
      .CLK       (CLK),
      .RST       (RST),
      .sig_i     (bus.i_signal[c]),
      .mode_i    (bus.i_edge_sel[2*c +: 2]),
      .width_i   (bus.i_width),
      .clr_i     (bus.i_clr),
      .pulse_o   (pulse_w[c]),
      .overrun_o (overrun_w[c])
    );
  end

  assign bus.o_pulse   = pulse_w;
  assign bus.o_overrun = overrun_w;

endmodule
